spi_slave_i: RTL and testbench

Receive-side counterpart of the DAC SPI master (`spi_master_o`). It deserializes 24-bit DAC frames (SYNC, SCLK, SDI) back into parallel words, oversampling all three lines in the `clk_i` domain. It is used as the loopback/DAC model behind `measure_unit` and as a capture point for threshold codes. Completed frames are presented with a valid/ack handshake; framing and overrun errors are flagged.

---
 rtl/dac_pkg.sv | 11 +
 rtl/sync_ff.sv | 20 ++
 rtl/spi_slave_i.sv | 124 ++++++++++++
 tb/tb_spi_slave_i.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the DAC SPI link: frame geometry and receiver states.
package dac_pkg;
  localparam int DAC_DATA_WIDTH = 24;
  localparam int DAC_CODE_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FULL
  } spi_rx_state_t;
endpackage

// File: rtl/sync_ff.sv
// One-bit multi-flop synchronizer with a selectable reset value, so idle-high
// lines do not produce a spurious edge when reset is released.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] stages;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) stages <= {STAGES{RST_VAL}};
    else          stages <= {stages[STAGES-2:0], d};
  end

  assign q = stages[STAGES-1];
endmodule

// File: rtl/spi_slave_i.sv
// Oversampling SPI receiver for 24-bit DAC frames. All three serial lines are
// synchronized into clk_i; completed frames are offered with a valid/ack handshake.
module spi_slave_i
  import dac_pkg::*;
#(
  parameter int DATA_WIDTH  = DAC_DATA_WIDTH,
  parameter int CODE_WIDTH  = DAC_CODE_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  sync_i,
  input  logic                  sclk_i,
  input  logic                  sdi_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CODE_WIDTH-1:0] code_o,
  output logic                  valid_o,
  input  logic                  ack_i,
  output logic                  busy_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic sync_s, sclk_s, sdi_s;
  logic sync_q, sclk_q, sdi_q;
  logic sync_rise, sync_fall, sclk_fall;

  spi_rx_state_t         state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  extra;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sync (
    .clk_i(clk_i), .arst_ni(arst_ni), .d(sync_i), .q(sync_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk_i(clk_i), .arst_ni(arst_ni), .d(sclk_i), .q(sclk_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk_i(clk_i), .arst_ni(arst_ni), .d(sdi_i), .q(sdi_s)
  );

  // Edge events are registered pulses; sdi is delayed alongside so the bit
  // captured is the one present when the sclk fall was seen.
  // NOTE: every clocked assignment is non-blocking so all flops update from
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      sync_q    <= 1'b1;
      sclk_q    <= 1'b1;
      sdi_q     <= 1'b0;
      sync_rise <= 1'b0;
      sync_fall <= 1'b0;
      sclk_fall <= 1'b0;
    end else begin
      sync_q    <= sync_s;
      sclk_q    <= sclk_s;
      sdi_q     <= sdi_s;
      sync_rise <= sync_s & ~sync_q;
      sync_fall <= ~sync_s & sync_q;
      sclk_fall <= ~sclk_s & sclk_q & ~sync_s;
    end
  end

  // NOTE: the shift register and counter are reset explicitly, since a frame
  // cut short by reset must not leak bits into the next one.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      extra       <= 1'b0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      if (valid_o && ack_i) valid_o <= 1'b0;

      case (state)
        IDLE: begin
          if (sync_fall) begin
            state <= SHIFT;
            cnt   <= '0;
            shreg <= '0;
          end
        end
        SHIFT: begin
          if (sync_rise) begin
            frame_err_o <= 1'b1;
            state       <= IDLE;
          end else if (sclk_fall) begin
            shreg <= {shreg[DATA_WIDTH-2:0], sdi_q};
            cnt   <= cnt + 1'b1;
            if (cnt == CNT_W'(DATA_WIDTH - 1)) state <= FULL;
          end
        end
        FULL: begin
          // A sync rise takes priority over a coincident sclk fall.
          if (sync_rise) begin
            if (extra) begin
              frame_err_o <= 1'b1;
            end else begin
              data_o    <= shreg;
              valid_o   <= 1'b1;
              overrun_o <= valid_o && !ack_i;
            end
            extra <= 1'b0;
            state <= IDLE;
          end else if (sclk_fall) begin
            extra <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign code_o = data_o[CODE_WIDTH-1:0];
  assign busy_o = (state != IDLE);
endmodule

// File: tb/tb_spi_slave_i.sv
// Scoreboard bench for spi_slave_i: the stimulus side predicts commit/error
// events from frame-level rules, a negedge monitor compares them as they appear.
module tb_spi_slave_i;
  localparam int DW = 24;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          arst_ni = 1'b0;
  logic          sync_i = 1'b1;
  logic          sclk_i = 1'b1;
  logic          sdi_i = 1'b0;
  logic          ack_i = 1'b0;
  logic [DW-1:0] data_o;
  logic [CW-1:0] code_o;
  logic          valid_o, busy_o, frame_err_o, overrun_o;

  spi_slave_i dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .sync_i(sync_i), .sclk_i(sclk_i),
    .sdi_i(sdi_i), .data_o(data_o), .code_o(code_o), .valid_o(valid_o),
    .ack_i(ack_i), .busy_o(busy_o), .frame_err_o(frame_err_o),
    .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  typedef enum {EV_COMMIT, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    logic [DW-1:0] data;
    logic          overrun;
  } ev_t;

  ev_t           exp_q[$];
  logic          model_valid = 1'b0;
  logic [DW-1:0] model_data  = '0;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference rules: a good frame commits; it overruns only if a frame is
  // still pending and the consumer is not acknowledging in that same cycle.
  task automatic expect_commit(input logic [DW-1:0] d, input bit ack_same);
    ev_t e;
    e.kind    = EV_COMMIT;
    e.data    = d;
    e.overrun = model_valid && !ack_same;
    exp_q.push_back(e);
    model_valid = 1'b1;
    model_data  = d;
  endtask

  task automatic expect_err();
    ev_t e;
    e.kind    = EV_ERR;
    e.data    = '0;
    e.overrun = 1'b0;
    exp_q.push_back(e);
  endtask

  function automatic logic [DW-1:0] fresh_data();
    logic [DW-1:0] d;
    d = DW'($urandom);
    if (d == model_data) d = d ^ 24'h000001;
    return d;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic start_frame();
    sync_i = 1'b0;
    wait_cyc(3);
  endtask

  // Sends bits[n-1] down to bits[0], MSB first; sdi changes with sclk rise.
  task automatic shift_bits(input logic [DW:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi_i  = bits[i];
      sclk_i = 1'b1;
      wait_cyc(3);
      sclk_i = 1'b0;
      wait_cyc(3);
    end
    sclk_i = 1'b1;
    wait_cyc(3);
  endtask

  // ack_same pulses ack_i exactly in the cycle the commit is decided.
  task automatic end_frame(input bit ack_same);
    sync_i = 1'b1;
    if (ack_same) begin
      wait_cyc(3);
      ack_i = 1'b1;
      wait_cyc(1);
      ack_i = 1'b0;
      wait_cyc(4);
    end else begin
      wait_cyc(8);
    end
  endtask

  task automatic ack_pulse();
    ack_i = 1'b1;
    wait_cyc(1);
    ack_i = 1'b0;
    model_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  data_o,      0);
    check({tag, "_code"},  code_o,      0);
    check({tag, "_valid"}, valid_o,     0);
    check({tag, "_busy"},  busy_o,      0);
    check({tag, "_ferr"},  frame_err_o, 0);
    check({tag, "_ovr"},   overrun_o,   0);
  endtask

  // Monitor: a commit is visible as valid rising or new data while valid.
  initial begin
    logic          v_prev = 1'b0;
    logic [DW-1:0] d_prev = '0;
    forever begin
      @(negedge clk_i);
      if (!arst_ni) begin
        v_prev = 1'b0;
        d_prev = '0;
      end else begin
        logic commit_seen;
        commit_seen = valid_o && (!v_prev || data_o != d_prev);
        if (frame_err_o || commit_seen) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", 1, 0);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            check("event_is_err", frame_err_o, (e.kind == EV_ERR));
            if (e.kind == EV_COMMIT) begin
              check("commit_data", data_o, e.data);
              check("commit_code", code_o, e.data[CW-1:0]);
              check("commit_overrun", overrun_o, e.overrun);
            end else begin
              check("err_overrun", overrun_o, 0);
            end
          end
        end else if (overrun_o) begin
          check("stray_overrun", 1, 0);
        end
        v_prev = valid_o;
        d_prev = data_o;
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    wait_cyc(4);
    check_reset_outputs("reset");
    arst_ni = 1'b1;
    wait_cyc(4);

    // Good frame with busy and commit latency checks, then ack.
    sync_i = 1'b0;
    wait_cyc(3);
    check("busy_early", busy_o, 0);
    wait_cyc(1);
    check("busy_rise", busy_o, 1);
    wait_cyc(2);
    shift_bits({1'b0, 24'h00A5C3}, 24);
    expect_commit(24'h00A5C3, 1'b0);
    sync_i = 1'b1;
    wait_cyc(3);
    check("valid_early", valid_o, 0);
    wait_cyc(1);
    check("valid_latency", valid_o, 1);
    check("code_a5c3", code_o, 16'hA5C3);
    wait_cyc(4);
    ack_pulse();
    check("valid_after_ack", valid_o, 0);
    wait_cyc(4);

    // Short frame: 23 falls.
    start_frame();
    shift_bits({1'b0, 24'h00FFFF}, 23);
    expect_err();
    end_frame(1'b0);
    check("short_valid_kept", valid_o, 0);
    check("short_data_kept", data_o, 24'h00A5C3);

    // Long frame: 25 falls.
    start_frame();
    shift_bits({24'h123456, 1'b1}, 25);
    expect_err();
    end_frame(1'b0);
    check("long_valid_kept", valid_o, 0);
    check("long_data_kept", data_o, 24'h00A5C3);

    // Overrun, then the same pair with ack in the commit cycle.
    for (int pass = 0; pass < 2; pass++) begin
      start_frame();
      shift_bits({1'b0, 24'h000001}, 24);
      expect_commit(24'h000001, 1'b0);
      end_frame(1'b0);
      start_frame();
      shift_bits({1'b0, 24'h000002}, 24);
      expect_commit(24'h000002, pass == 1);
      end_frame(pass == 1);
      check("pair_data", data_o, 24'h000002);
      check("pair_valid", valid_o, 1);
      ack_pulse();
      wait_cyc(2);
    end

    // Reset mid-frame, then a clean full frame.
    start_frame();
    shift_bits({1'b0, 24'hABCDEF}, 12);
    arst_ni = 1'b0;
    sync_i  = 1'b1;
    sclk_i  = 1'b1;
    wait_cyc(2);
    check_reset_outputs("midreset");
    model_valid = 1'b0;
    model_data  = '0;
    arst_ni = 1'b1;
    wait_cyc(4);
    start_frame();
    shift_bits({1'b0, 24'hFFFFFF}, 24);
    expect_commit(24'hFFFFFF, 1'b0);
    end_frame(1'b0);
    ack_pulse();
    wait_cyc(2);

    // sclk fall coincident with sync rise after 24 bits: edge discarded.
    d = fresh_data();
    start_frame();
    shift_bits({1'b0, d}, 24);
    expect_commit(d, 1'b0);
    sync_i = 1'b1;
    sclk_i = 1'b0;
    wait_cyc(6);
    sclk_i = 1'b1;
    wait_cyc(4);

    // Randomized frames.
    for (int k = 0; k < 24; k++) begin
      int kind;
      kind = $urandom_range(0, 4);
      d    = fresh_data();
      start_frame();
      case (kind)
        0: begin shift_bits({1'b0, d}, 24); expect_commit(d, 1'b0); end_frame(1'b0); end
        1: begin shift_bits({1'b0, d}, 24); expect_commit(d, 1'b0); end_frame(1'b0); ack_pulse(); end
        2: begin shift_bits({1'b0, d}, int'($urandom_range(1, 23))); expect_err(); end_frame(1'b0); end
        3: begin shift_bits({d, 1'($urandom)}, 25); expect_err(); end_frame(1'b0); end
        default: begin shift_bits({1'b0, d}, 24); expect_commit(d, 1'b1); end_frame(1'b1); end
      endcase
      wait_cyc(2);
    end

    wait_cyc(10);
    check("events_pending", exp_q.size(), 0);
    check("final_valid", valid_o, model_valid);
    check("final_data", data_o, model_data);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
